turn_controller: RTL and testbench

- Sequences one player move per turn.
- Flow: piece selection, move-generator handshake, target confirmation, board write, side switch.
- Sits between the input/UI decoder, the move generator (64-bit legal-move mask) and the board RAM.
- Detects king capture to end the game.

---
 rtl/turn_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_turn_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Turn sequencer for a two-player board game: selection, move-generator handshake,
// target confirmation, board write and side switch. Optional turn timer under TURN_TIMEOUT_EN.
module turn_controller #(
   parameter logic [2:0]  KING_CODE    = 3'b110,
   parameter int          MOVE_CNT_W   = 10,
   parameter logic [31:0] TURN_TIMEOUT = 32'd50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_game,
   input  logic                  select_valid,
   input  logic                  confirm,
   input  logic                  cancel,
   input  logic [5:0]            select_pos,
   input  logic [3:0]            board_piece,
   output logic                  gen_req,
   output logic [5:0]            gen_from,
   input  logic                  gen_done,
   input  logic [63:0]           gen_moves,
   output logic                  wr_en,
   output logic [5:0]            wr_from,
   output logic [5:0]            wr_to,
   input  logic                  wr_ack,
   output logic                  side_to_move,
   output logic                  error,
   output logic                  game_over,
   output logic                  winner,
   output logic                  timeout,
   output logic [MOVE_CNT_W-1:0] move_count,
   output logic [2:0]            state_dbg
);

   // state  | meaning
   // IDLE   | waiting for first start_game
   // SELECT | waiting for the side to move to pick one of its pieces
   // GEN    | gen_req high, waiting for the legal-move mask
   // TARGET | waiting for confirm on a legal square (or cancel)
   // COMMIT | wr_en high, waiting for the board write ack
   // OVER   | game finished, outputs held until restart
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_GEN    = 3'd2,
      S_TARGET = 3'd3,
      S_COMMIT = 3'd4,
      S_OVER   = 3'd5
   } state_t;

   state_t                state_q, state_nxt;
   logic                  side_q, side_nxt;
   logic [5:0]            from_q, from_nxt;
   logic [5:0]            to_q, to_nxt;
   logic [63:0]           mask_q, mask_nxt;
   logic                  king_q, king_nxt;
   logic                  over_q, over_nxt;
   logic                  winner_q, winner_nxt;
   logic                  error_q, error_nxt;
   logic [MOVE_CNT_W-1:0] count_q, count_nxt;
   logic                  piece_ok;

`ifdef TURN_TIMEOUT_EN
   logic [31:0]           tcnt_q, tcnt_nxt;
   logic                  tmo_q, tmo_nxt;
`endif

   assign piece_ok = (board_piece[2:0] != 3'b000) && (board_piece[3] == side_q);

   always_comb begin
      state_nxt  = state_q;
      side_nxt   = side_q;
      from_nxt   = from_q;
      to_nxt     = to_q;
      mask_nxt   = mask_q;
      king_nxt   = king_q;
      over_nxt   = over_q;
      winner_nxt = winner_q;
      count_nxt  = count_q;
      error_nxt  = 1'b0;
`ifdef TURN_TIMEOUT_EN
      tcnt_nxt   = tcnt_q;
      tmo_nxt    = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_game) begin
               state_nxt = S_SELECT;
               side_nxt  = 1'b0;
               count_nxt = '0;
            end
         end
         S_SELECT: begin
            if (select_valid) begin
               if (piece_ok) begin
                  from_nxt  = select_pos;
                  state_nxt = S_GEN;
               end else begin
                  error_nxt = 1'b1;
               end
            end
         end
         S_GEN: begin
            if (gen_done) begin
               mask_nxt = gen_moves;
               if (gen_moves == 64'd0) begin
                  error_nxt = 1'b1;
                  state_nxt = S_SELECT;
               end else begin
                  state_nxt = S_TARGET;
               end
            end
         end
         S_TARGET: begin
            if (cancel) begin
               state_nxt = S_SELECT;
            end else if (confirm) begin
               if (mask_q[select_pos]) begin
                  to_nxt    = select_pos;
                  king_nxt  = (board_piece[2:0] == KING_CODE) && (board_piece[3] != side_q);
                  state_nxt = S_COMMIT;
               end else begin
                  error_nxt = 1'b1;
               end
            end
         end
         S_COMMIT: begin
            if (wr_ack) begin
               if (count_q != '1) count_nxt = count_q + 1'b1;
               if (king_q) begin
                  state_nxt  = S_OVER;
                  over_nxt   = 1'b1;
                  winner_nxt = side_q;
               end else begin
                  side_nxt  = ~side_q;
                  state_nxt = S_SELECT;
               end
            end
         end
         S_OVER: begin
            if (start_game) begin
               state_nxt  = S_SELECT;
               over_nxt   = 1'b0;
               winner_nxt = 1'b0;
               side_nxt   = 1'b0;
               count_nxt  = '0;
`ifdef TURN_TIMEOUT_EN
               tmo_nxt    = 1'b0;
`endif
            end
         end
         default: state_nxt = S_IDLE;
      endcase

`ifdef TURN_TIMEOUT_EN
      // The timer spans a whole turn, so cancel and empty-mask retries keep counting.
      if (state_q == S_SELECT || state_q == S_GEN || state_q == S_TARGET) begin
         if (tcnt_q == TURN_TIMEOUT - 32'd1) begin
            state_nxt  = S_OVER;
            over_nxt   = 1'b1;
            winner_nxt = ~side_q;
            tmo_nxt    = 1'b1;
            error_nxt  = 1'b0;
         end else begin
            tcnt_nxt = tcnt_q + 32'd1;
         end
      end else if (state_nxt == S_SELECT) begin
         tcnt_nxt = 32'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         side_q   <= 1'b0;
         from_q   <= 6'd0;
         to_q     <= 6'd0;
         mask_q   <= 64'd0;
         king_q   <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
         error_q  <= 1'b0;
         count_q  <= '0;
`ifdef TURN_TIMEOUT_EN
         tcnt_q   <= 32'd0;
         tmo_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_nxt;
         side_q   <= side_nxt;
         from_q   <= from_nxt;
         to_q     <= to_nxt;
         mask_q   <= mask_nxt;
         king_q   <= king_nxt;
         over_q   <= over_nxt;
         winner_q <= winner_nxt;
         error_q  <= error_nxt;
         count_q  <= count_nxt;
`ifdef TURN_TIMEOUT_EN
         tcnt_q   <= tcnt_nxt;
         tmo_q    <= tmo_nxt;
`endif
      end
   end

   assign gen_req      = (state_q == S_GEN);
   assign gen_from     = from_q;
   assign wr_en        = (state_q == S_COMMIT);
   assign wr_from      = from_q;
   assign wr_to        = to_q;
   assign side_to_move = side_q;
   assign error        = error_q;
   assign game_over    = over_q;
   assign winner       = winner_q;
   assign move_count   = count_q;
   assign state_dbg    = state_q;

`ifdef TURN_TIMEOUT_EN
   assign timeout = tmo_q;
`else
   logic unused_turn_timeout;
   assign unused_turn_timeout = ^TURN_TIMEOUT;
   assign timeout             = 1'b0;
`endif

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller; the timeout scenario runs only when
// TURN_TIMEOUT_EN is defined (DUT then built with a 20-cycle turn limit).
module tb_turn_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_game, select_valid, confirm, cancel;
   logic [5:0]  select_pos;
   logic [3:0]  board_piece;
   logic        gen_req;
   logic [5:0]  gen_from;
   logic        gen_done;
   logic [63:0] gen_moves;
   logic        wr_en;
   logic [5:0]  wr_from, wr_to;
   logic        wr_ack;
   logic        side_to_move, error, game_over, winner, timeout;
   logic [9:0]  move_count;
   logic [2:0]  state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   turn_controller #(
`ifdef TURN_TIMEOUT_EN
      .TURN_TIMEOUT(32'd20)
`else
      .TURN_TIMEOUT(32'd50_000_000)
`endif
   ) dut (
      .clk(clk), .rst(rst), .start_game(start_game), .select_valid(select_valid),
      .confirm(confirm), .cancel(cancel), .select_pos(select_pos), .board_piece(board_piece),
      .gen_req(gen_req), .gen_from(gen_from), .gen_done(gen_done), .gen_moves(gen_moves),
      .wr_en(wr_en), .wr_from(wr_from), .wr_to(wr_to), .wr_ack(wr_ack),
      .side_to_move(side_to_move), .error(error), .game_over(game_over), .winner(winner),
      .timeout(timeout), .move_count(move_count), .state_dbg(state_dbg)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_game = 1'b1; tick(); start_game = 1'b0;
   endtask

   task automatic do_select(input logic [5:0] pos, input logic [3:0] pc);
      select_valid = 1'b1; select_pos = pos; board_piece = pc;
      tick();
      select_valid = 1'b0; board_piece = 4'd0;
   endtask

   task automatic do_gen(input logic [63:0] m);
      gen_done = 1'b1; gen_moves = m;
      tick();
      gen_done = 1'b0; gen_moves = 64'd0;
   endtask

   task automatic do_confirm(input logic [5:0] pos, input logic [3:0] pc);
      confirm = 1'b1; select_pos = pos; board_piece = pc;
      tick();
      confirm = 1'b0; board_piece = 4'd0;
   endtask

   task automatic do_ack();
      wr_ack = 1'b1; tick(); wr_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start_game = 1'b0; select_valid = 1'b0; confirm = 1'b0; cancel = 1'b0;
      select_pos = 6'd0; board_piece = 4'd0; gen_done = 1'b0; gen_moves = 64'd0; wr_ack = 1'b0;
      tick(); tick();
      chk("rst_state", state_dbg, 0);
      chk("rst_gen_req", gen_req, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_side", side_to_move, 0);
      chk("rst_count", move_count, 0);
      chk("rst_over", game_over, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b1;
      tick();
      do_start();
      chk("start_state", state_dbg, 1);

      // wrong-colour and empty selections
      do_select(6'd5, 4'b1001);
      chk("sel_black_err", error, 1);
      chk("sel_black_state", state_dbg, 1);
      chk("sel_black_genreq", gen_req, 0);
      tick();
      chk("err_one_cycle", error, 0);
      do_select(6'd6, 4'b0000);
      chk("sel_empty_err", error, 1);
      chk("sel_empty_state", state_dbg, 1);

      // full white move 12 -> 28
      do_select(6'd12, 4'b0001);
      chk("sel_ok_err", error, 0);
      chk("gen_state", state_dbg, 2);
      chk("gen_req_hi", gen_req, 1);
      chk("gen_from", gen_from, 12);
      tick(); tick();
      chk("gen_req_held", gen_req, 1);
      do_gen(64'h1 << 28);
      chk("target_state", state_dbg, 3);
      chk("gen_req_dropped", gen_req, 0);
      do_confirm(6'd28, 4'b0000);
      chk("commit_state", state_dbg, 4);
      chk("wr_en_hi", wr_en, 1);
      chk("wr_from", wr_from, 12);
      chk("wr_to", wr_to, 28);
      tick(); tick();
      chk("wr_en_held", wr_en, 1);
      chk("wr_to_held", wr_to, 28);
      do_ack();
      chk("ack_wr_en", wr_en, 0);
      chk("ack_state", state_dbg, 1);
      chk("ack_side", side_to_move, 1);
      chk("ack_count", move_count, 1);

      // black: empty mask, then illegal confirm, ignored select, cancel+confirm
      do_select(6'd52, 4'b1001);
      chk("blk_gen_state", state_dbg, 2);
      do_gen(64'd0);
      chk("nomask_err", error, 1);
      chk("nomask_state", state_dbg, 1);
      do_select(6'd52, 4'b1001);
      do_gen((64'h1 << 44) | (64'h1 << 36));
      chk("blk_target", state_dbg, 3);
      do_confirm(6'd20, 4'b0000);
      chk("badconf_err", error, 1);
      chk("badconf_state", state_dbg, 3);
      do_select(6'd44, 4'b1001);
      chk("tgt_sel_ignored", state_dbg, 3);
      chk("tgt_sel_noerr", error, 0);
      confirm = 1'b1; cancel = 1'b1; select_pos = 6'd44;
      tick();
      confirm = 1'b0; cancel = 1'b0;
      chk("cancel_state", state_dbg, 1);
      chk("cancel_noerr", error, 0);
      chk("cancel_no_wr", wr_en, 0);
      do_select(6'd52, 4'b1001);
      do_gen(64'h1 << 44);
      do_confirm(6'd44, 4'b0000);
      do_ack();
      chk("blk_side", side_to_move, 0);
      chk("blk_count", move_count, 2);

      // white captures the black king
      do_select(6'd3, 4'b0101);
      do_gen(64'h1 << 59);
      do_confirm(6'd59, 4'b1110);
      chk("king_commit", state_dbg, 4);
      do_ack();
      chk("over_state", state_dbg, 5);
      chk("over_flag", game_over, 1);
      chk("over_winner", winner, 0);
      chk("over_side", side_to_move, 0);
      chk("over_count", move_count, 3);
      do_select(6'd1, 4'b0001);
      chk("over_noerr", error, 0);
      chk("over_held", game_over, 1);
      do_start();
      chk("restart_state", state_dbg, 1);
      chk("restart_count", move_count, 0);
      chk("restart_over", game_over, 0);

      // reset while a board write is pending
      do_select(6'd8, 4'b0001);
      do_gen(64'h1 << 16);
      do_confirm(6'd16, 4'b0000);
      chk("pre_rst_wr_en", wr_en, 1);
      rst = 1'b0;
      tick();
      chk("rst_commit_wr_en", wr_en, 0);
      chk("rst_commit_state", state_dbg, 0);
      chk("rst_commit_wr_to", wr_to, 0);
      rst = 1'b1;
      tick();

`ifdef TURN_TIMEOUT_EN
      do_start();
      do_select(6'd12, 4'b0001);
      do_gen(64'h1 << 28);
      for (int i = 0; i < 17; i++) tick();
      chk("tmo_not_yet", state_dbg, 3);
      chk("tmo_not_yet_flag", timeout, 0);
      tick();
      chk("tmo_state", state_dbg, 5);
      chk("tmo_flag", timeout, 1);
      chk("tmo_over", game_over, 1);
      chk("tmo_winner", winner, 1);
      chk("tmo_gen_req", gen_req, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
